// File: rtl/mixer_acq_pkg.sv
// Shared types and defaults for the mixer acquisition sequencer.
// MIX_LATENCY_DEF must track the quad mixer core pipeline depth.
package mixer_acq_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DLY_W_DEF       = 32;
    localparam int MIX_LATENCY_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DEAD,
        FILL,
        CAPTURE,
        REPDLY,
        DONE
    } acq_state_e;

endpackage

// File: rtl/acq_down_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module acq_down_counter
    import mixer_acq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mixer_acq_ctrl.sv
// Acquisition sequencer: trig -> dead time -> mixer fill -> N capture words, repeated per scan.
// Optional macro ACQ_PHASE_CYCLE_EN adds phase_sel/cap_neg for CYCLOPS phase cycling.
module mixer_acq_ctrl
    import mixer_acq_pkg::*;
#(
    parameter int MIX_LATENCY = MIX_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DLY_W       = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             trig,
    input  logic [CNT_W-1:0] cfg_dead_time,
    input  logic [CNT_W-1:0] cfg_num_words,
    input  logic [CNT_W-1:0] cfg_num_scans,
    input  logic [DLY_W-1:0] cfg_rep_delay,
    input  logic             cap_ready,
    output logic             mix_en,
    output logic             cap_valid,
    output logic             cap_last,
    output logic [CNT_W-1:0] scan_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             ovf_err,
`ifdef ACQ_PHASE_CYCLE_EN
    output logic [1:0]       phase_sel,
    output logic             cap_neg,
`endif
    output logic             trig_err
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(MIX_LATENCY - 1);
    localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);

    acq_state_e       state_q, state_d;
    logic             mix_en_q, mix_en_d, cap_valid_q, cap_valid_d, cap_last_q, cap_last_d;
    logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic             ovf_q, ovf_d, trig_err_q, trig_err_d;
    logic [CNT_W-1:0] scan_idx_q, scan_idx_d;
    logic [CNT_W-1:0] dead_q, dead_d, words_q, words_d, scans_q, scans_d;
    logic [DLY_W-1:0] rep_q, rep_d;
    logic             cnt_load, cnt_dec, cnt_zero, dly_load, dly_dec, dly_zero;
    logic [CNT_W-1:0] cnt_val;
    logic [DLY_W-1:0] dly_val;

    acq_down_counter #(.W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .load(cnt_load), .load_val(cnt_val), .dec(cnt_dec), .zero(cnt_zero)
    );

    acq_down_counter #(.W(DLY_W)) u_dly (
        .clk(clk), .rst(rst), .load(dly_load), .load_val(dly_val), .dec(dly_dec), .zero(dly_zero)
    );

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        dead_d     = dead_q;
        words_d    = words_q;
        scans_d    = scans_q;
        rep_d      = rep_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        dly_load   = 1'b0;
        dly_val    = '0;
        dly_dec    = 1'b0;
        cap_last_d = 1'b0;
        aborted_d  = 1'b0;
        ovf_d      = ovf_q | (cap_valid_q & ~cap_ready);
        trig_err_d = trig_err_q | (trig && (state_q != IDLE) && (state_q != ARM));

        if (abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dead_d     = cfg_dead_time;
                        words_d    = (cfg_num_words == '0) ? ONE : cfg_num_words;
                        scans_d    = (cfg_num_scans == '0) ? ONE : cfg_num_scans;
                        rep_d      = cfg_rep_delay;
                        scan_idx_d = '0;
                        ovf_d      = 1'b0;
                        trig_err_d = 1'b0;
                        state_d    = ARM;
                    end
                end
                ARM: begin
                    if (trig) begin
                        cnt_load = 1'b1;
                        if (dead_q == '0) begin
                            state_d = FILL;
                            cnt_val = FILL_LOAD;
                        end else begin
                            state_d = DEAD;
                            cnt_val = dead_q - ONE;
                        end
                    end
                end
                DEAD: begin
                    if (cnt_zero) begin
                        state_d  = FILL;
                        cnt_load = 1'b1;
                        cnt_val  = FILL_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                FILL: begin
                    // Word counter is preloaded with N-2 so its zero flag marks the cycle before the last word.
                    if (cnt_zero) begin
                        state_d = CAPTURE;
                        if (words_q == ONE) begin
                            cap_last_d = 1'b1;
                        end else begin
                            cnt_load = 1'b1;
                            cnt_val  = words_q - TWO;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cap_last_q) begin
                        if (scan_idx_q == scans_q - ONE) begin
                            state_d = DONE;
                        end else begin
                            scan_idx_d = scan_idx_q + ONE;
                            if (rep_q == '0) begin
                                state_d = ARM;
                            end else begin
                                state_d  = REPDLY;
                                dly_load = 1'b1;
                                dly_val  = rep_q - DLY_ONE;
                            end
                        end
                    end else if (cnt_zero) begin
                        cap_last_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                REPDLY: begin
                    if (dly_zero) begin
                        state_d = ARM;
                    end else begin
                        dly_dec = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        mix_en_d    = (state_d == FILL) || (state_d == CAPTURE);
        cap_valid_d = (state_d == CAPTURE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mix_en_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            ovf_q       <= 1'b0;
            trig_err_q  <= 1'b0;
            scan_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            mix_en_q    <= mix_en_d;
            cap_valid_q <= cap_valid_d;
            cap_last_q  <= cap_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            ovf_q       <= ovf_d;
            trig_err_q  <= trig_err_d;
            scan_idx_q  <= scan_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        dead_q  <= dead_d;
        words_q <= words_d;
        scans_q <= scans_d;
        rep_q   <= rep_d;
    end

`ifdef ACQ_PHASE_CYCLE_EN
    logic [1:0] phase_sel_q, phase_sel_d;
    logic       cap_neg_q, cap_neg_d;

    always_comb begin
        phase_sel_d = scan_idx_d[1:0];
        cap_neg_d   = cap_valid_d & scan_idx_d[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_sel_q <= 2'b00;
            cap_neg_q   <= 1'b0;
        end else begin
            phase_sel_q <= phase_sel_d;
            cap_neg_q   <= cap_neg_d;
        end
    end

    assign phase_sel = phase_sel_q;
    assign cap_neg   = cap_neg_q;
`endif

    assign mix_en    = mix_en_q;
    assign cap_valid = cap_valid_q;
    assign cap_last  = cap_last_q;
    assign scan_idx  = scan_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign ovf_err   = ovf_q;
    assign trig_err  = trig_err_q;

endmodule

// File: tb/tb_mixer_acq_ctrl.sv
// Directed bench for mixer_acq_ctrl; outputs are logged per cycle at the falling edge
// and checked against hand-computed cycle offsets from each trig.
module tb_mixer_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, trig, cap_ready;
    logic [15:0] cfg_dead_time, cfg_num_words, cfg_num_scans;
    logic [31:0] cfg_rep_delay;
    logic        mix_en, cap_valid, cap_last, busy, done, aborted, ovf_err, trig_err;
    logic [15:0] scan_idx;
`ifdef ACQ_PHASE_CYCLE_EN
    logic [1:0]  phase_sel;
    logic        cap_neg;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    localparam int SIG_MIX = 0, SIG_CV = 1, SIG_CL = 2, SIG_DONE = 3, SIG_ABT = 4, SIG_BUSY = 5;
    bit          lg    [6][4096];
    logic [15:0] lg_si [4096];

    mixer_acq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .cfg_dead_time(cfg_dead_time), .cfg_num_words(cfg_num_words),
        .cfg_num_scans(cfg_num_scans), .cfg_rep_delay(cfg_rep_delay),
        .cap_ready(cap_ready), .mix_en(mix_en), .cap_valid(cap_valid), .cap_last(cap_last),
        .scan_idx(scan_idx), .busy(busy), .done(done), .aborted(aborted), .ovf_err(ovf_err),
`ifdef ACQ_PHASE_CYCLE_EN
        .phase_sel(phase_sel), .cap_neg(cap_neg),
`endif
        .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 4096) begin
            lg[SIG_MIX][cyc]  <= mix_en;
            lg[SIG_CV][cyc]   <= cap_valid;
            lg[SIG_CL][cyc]   <= cap_last;
            lg[SIG_DONE][cyc] <= done;
            lg[SIG_ABT][cyc]  <= aborted;
            lg[SIG_BUSY][cyc] <= busy;
            lg_si[cyc]        <= scan_idx;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_hi(int sel, int from, int to);
        int n = 0;
        for (int i = from; i <= to; i++)
            if (i >= 0 && i < 4096 && lg[sel][i]) n++;
        return n;
    endfunction

    function automatic int first_hi(int sel, int from, int to);
        for (int i = from; i <= to; i++)
            if (i >= 0 && i < 4096 && lg[sel][i]) return i;
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) wait_cyc(1);
    endtask

    task automatic set_cfg(input int d, input int w, input int s, input int r);
        cfg_dead_time = 16'(d);
        cfg_num_words = 16'(w);
        cfg_num_scans = 16'(s);
        cfg_rep_delay = 32'(r);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_trig(output int t);
        t    = cyc;
        trig = 1'b1;
        wait_cyc(1);
        trig = 1'b0;
    endtask

    int t, t1, t2, t3, tx, ts;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0; cap_ready = 1'b1;
        set_cfg(0, 0, 0, 0);
        wait_cyc(3);
        chk("rst_mix_en", mix_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scan_idx", scan_idx, 0);
        chk("rst_flags", {cap_valid, cap_last, done, aborted, ovf_err, trig_err}, 0);
        rst = 1'b0;
        wait_cyc(2);

        // Basic single scan: D=3, 4 words
        set_cfg(3, 4, 1, 0);
        pulse_start();
        wait_cyc(2);
        pulse_trig(t);
        goto(t + 14);
        chk("basic_busy_arm", count_hi(SIG_BUSY, t, t), 1);
        chk("basic_mix_first", first_hi(SIG_MIX, t, t + 13), t + 4);
        chk("basic_mix_len", count_hi(SIG_MIX, t, t + 13), 6);
        chk("basic_cv_first", first_hi(SIG_CV, t, t + 13), t + 6);
        chk("basic_cv_len", count_hi(SIG_CV, t, t + 13), 4);
        chk("basic_last_at", first_hi(SIG_CL, t, t + 13), t + 9);
        chk("basic_last_cnt", count_hi(SIG_CL, t, t + 13), 1);
        chk("basic_done_at", first_hi(SIG_DONE, t, t + 13), t + 10);
        chk("basic_done_cnt", count_hi(SIG_DONE, t, t + 13), 1);
        chk("basic_idle_busy", busy, 0);

        // Multi-scan with a stray trig during the repetition delay
        set_cfg(2, 4, 3, 5);
        pulse_start();
        wait_cyc(1);
        pulse_trig(t1);
        goto(t1 + 10);
        pulse_trig(tx);
        goto(t1 + 16);
        pulse_trig(t2);
        goto(t2 + 16);
        pulse_trig(t3);
        goto(t3 + 12);
        chk("multi_cv_total", count_hi(SIG_CV, t1, t3 + 11), 12);
        chk("multi_last_total", count_hi(SIG_CL, t1, t3 + 11), 3);
        chk("multi_done_cnt", count_hi(SIG_DONE, t1, t3 + 11), 1);
        chk("multi_done_at", first_hi(SIG_DONE, t1, t3 + 11), t3 + 9);
        chk("multi_scan2_cv", first_hi(SIG_CV, t2, t2 + 12), t2 + 5);
        chk("multi_stray_mix", count_hi(SIG_MIX, tx, t2), 0);
        chk("multi_idx0", lg_si[t1 + 5], 0);
        chk("multi_idx1", lg_si[t2 + 5], 1);
        chk("multi_idx2", lg_si[t3 + 5], 2);
        chk("multi_idx_hold", scan_idx, 2);
        chk("multi_trig_err", trig_err, 1);

        // Zero cases, with start and trig together in IDLE
        set_cfg(0, 0, 0, 0);
        ts = cyc;
        start = 1'b1; trig = 1'b1;
        wait_cyc(1);
        start = 1'b0; trig = 1'b0;
        chk("zero_trig_err_clr", trig_err, 0);
        wait_cyc(4);
        chk("zero_armed_busy", busy, 1);
        chk("zero_no_early_mix", count_hi(SIG_MIX, ts, ts + 4), 0);
        pulse_trig(t);
        goto(t + 7);
        chk("zero_mix_first", first_hi(SIG_MIX, t, t + 6), t + 1);
        chk("zero_cv_cnt", count_hi(SIG_CV, t, t + 6), 1);
        chk("zero_cv_at", first_hi(SIG_CV, t, t + 6), t + 3);
        chk("zero_last_at", first_hi(SIG_CL, t, t + 6), t + 3);
        chk("zero_done_at", first_hi(SIG_DONE, t, t + 6), t + 4);
        chk("zero_done_cnt", count_hi(SIG_DONE, t, t + 6), 1);

        // Abort after two of eight words
        set_cfg(1, 8, 1, 0);
        pulse_start();
        wait_cyc(1);
        pulse_trig(t);
        goto(t + 5);
        abort = 1'b1;
        wait_cyc(1);
        abort = 1'b0;
        chk("abort_mix_off", mix_en, 0);
        chk("abort_cv_off", cap_valid, 0);
        chk("abort_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        goto(t + 12);
        chk("abort_cv_cnt", count_hi(SIG_CV, t, t + 11), 2);
        chk("abort_no_done", count_hi(SIG_DONE, t, t + 11), 0);
        chk("abort_pulse_cnt", count_hi(SIG_ABT, t, t + 11), 1);

        // abort beats start in the same cycle, then a normal run
        set_cfg(0, 2, 1, 0);
        start = 1'b1; abort = 1'b1;
        wait_cyc(1);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_pulse", aborted, 1);
        pulse_start();
        wait_cyc(1);
        pulse_trig(t);
        goto(t + 8);
        chk("rerun_cv_cnt", count_hi(SIG_CV, t, t + 7), 2);
        chk("rerun_last_at", first_hi(SIG_CL, t, t + 7), t + 4);
        chk("rerun_done_at", first_hi(SIG_DONE, t, t + 7), t + 5);

        // Overflow: cap_ready low outside capture is harmless, inside it sticks
        set_cfg(0, 4, 1, 0);
        pulse_start();
        cap_ready = 1'b0;
        wait_cyc(1);
        cap_ready = 1'b1;
        wait_cyc(1);
        chk("ovf_idle_ready_low", ovf_err, 0);
        pulse_trig(t);
        goto(t + 4);
        cap_ready = 1'b0;
        wait_cyc(1);
        cap_ready = 1'b1;
        chk("ovf_set", ovf_err, 1);
        goto(t + 10);
        chk("ovf_sticky", ovf_err, 1);
        chk("ovf_cv_cnt", count_hi(SIG_CV, t, t + 9), 4);
        chk("ovf_done_cnt", count_hi(SIG_DONE, t, t + 9), 1);

        // New start clears ovf_err; async reset mid-capture
        set_cfg(0, 8, 1, 0);
        pulse_start();
        chk("ovf_clr_on_start", ovf_err, 0);
        pulse_trig(t);
        goto(t + 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_mix_off", mix_en, 0);
        chk("arst_cv_off", cap_valid, 0);
        chk("arst_busy", busy, 0);
        wait_cyc(2);
        rst = 1'b0;
        goto(t + 20);
        chk("arst_no_done", count_hi(SIG_DONE, t + 5, t + 19), 0);
        chk("arst_no_abort", count_hi(SIG_ABT, t + 5, t + 19), 0);

`ifdef ACQ_PHASE_CYCLE_EN
        set_cfg(0, 1, 5, 0);
        pulse_start();
        wait_cyc(1);
        for (int k = 0; k < 5; k++) begin
            pulse_trig(t);
            goto(t + 3);
            chk("phase_cv", cap_valid, 1);
            chk("phase_sel", phase_sel, k % 4);
            chk("phase_neg", cap_neg, (k % 4) / 2);
            goto(t + 5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mixer_acq_ctrl.md
Name: mixer_acq_ctrl

Overview:
Acquisition sequencer for the quadrature mixer datapath. After each pulse-sequence trigger it waits out receiver dead time, then enables the DDS/mixer (drives the mixer's dds_val). It waits for the mixer pipeline to fill, then frames exactly N valid 4-sample I/Q words for the downstream capture/accumulator. It repeats this for a programmed number of scans, with a repetition delay between scans. It sits between the host register bank, the pulse sequencer, and the quad mixer / capture FIFO.

Parameters:
MIX_LATENCY, 2, clk cycles from mix_en rising to first valid mixer output word (input register + multiplier core), legal 1..15
CNT_W, 16, width of dead-time, word and scan counters
DLY_W, 32, width of repetition-delay counter

Ports:
clk  in  1  system clock (sample-word rate)
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins an acquisition run (honoured in IDLE only)
abort  in  1  single-cycle pulse; terminates the run from any state
trig  in  1  single-cycle pulse from pulse sequencer: end of RF pulse
cfg_dead_time  in  CNT_W  cycles from trig to mix_en
cfg_num_words  in  CNT_W  words captured per scan (0 treated as 1)
cfg_num_scans  in  CNT_W  scans per run (0 treated as 1)
cfg_rep_delay  in  DLY_W  cycles between end of capture and re-arm
cap_ready  in  1  downstream capture FIFO can accept a word
mix_en  out  1  drives mixer dds_val
cap_valid  out  1  current mixer output word is a capture word
cap_last  out  1  with cap_valid: last word of the scan
scan_idx  out  CNT_W  index of the current scan, 0-based
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the final scan completes
aborted  out  1  one-cycle pulse on abort
ovf_err  out  1  sticky: cap_valid was high while cap_ready was low
trig_err  out  1  sticky: trig arrived outside ARM while busy

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs are registered.
- start in IDLE: latch all cfg_* into shadow registers, clear scan_idx, ovf_err and trig_err, go to ARM. cfg changes during a run have no effect.
- start outside IDLE is ignored.
- States:
  - IDLE: wait for start.
  - ARM: wait for trig. On trig, go to DEAD, or to FILL if dead_time = 0.
  - DEAD: count dead_time cycles, then go to FILL.
  - FILL: mix_en = 1 for MIX_LATENCY cycles, cap_valid = 0, then go to CAPTURE.
  - CAPTURE: mix_en = 1, cap_valid = 1 every cycle for num_words cycles. cap_last is asserted on the final word. After the last word:
    - if scan_idx + 1 = num_scans, go to DONE;
    - else increment scan_idx and go to REPDLY, or to ARM if rep_delay = 0.
  - REPDLY: mix_en = 0; count rep_delay cycles, then go to ARM.
  - DONE: done = 1 for one cycle, then go to IDLE. scan_idx holds its final value until the next start.
- Timing: trig at cycle t with dead_time D gives mix_en first high at t + 1 + D and cap_valid first high at t + 1 + D + MIX_LATENCY. mix_en falls on the cycle after cap_last.
- No backpressure: capture is not stalled. cap_ready low during cap_valid sets ovf_err, and the word still counts.
- trig while busy and not in ARM is ignored and sets trig_err.
- start and trig arriving in the same cycle in IDLE: start is taken, trig is ignored.
- abort has priority over every other input, including start in the same cycle. Next cycle: state IDLE, mix_en, cap_valid and cap_last = 0, aborted = 1, done = 0. Sticky flags are kept.
- Async rst mid-capture: outputs clear immediately; no done or aborted pulse.

Optional Feature:
ACQ_PHASE_CYCLE_EN
- Defined: adds output phase_sel [1:0] = scan_idx[1:0], registered, constant for the whole scan. It implements CYCLOPS receiver phase cycling (0/90/180/270). Also adds output cap_neg = phase_sel[1], aligned with cap_valid, which tells the accumulator to subtract the word.
- Undefined: these ports do not exist and scan_idx has no phase role.

Decomposition:
- Shared package mixer_acq_pkg holds:
  - the state enum (IDLE, ARM, DEAD, FILL, CAPTURE, REPDLY, DONE);
  - CNT_W and DLY_W defaults;
  - the MIX_LATENCY default, which must match the mixer core latency.
- One sub-module, acq_down_counter: loadable down-counter with a zero flag. It is instantiated for the dead-time/fill/word counter and for the repetition-delay counter.

Test Plan:
- Basic: D=3, words=4, scans=1, MIX_LATENCY=2; trig at t=10 -> mix_en high t=14..19, cap_valid t=16..19, cap_last t=19, done t=20.
- Multi-scan: scans=3, rep_delay=5, three trigs -> scan_idx 0/1/2, four words each, one done. An extra trig during REPDLY is ignored and sets trig_err.
- Zero cases: D=0, rep_delay=0, words=0 -> mix_en at t+1, one word with cap_valid and cap_last together; scans=0 behaves as scans=1.
- Abort mid-CAPTURE after 2 of 8 words -> next cycle mix_en, cap_valid = 0, aborted pulse, done never asserted. A new start then runs normally.
- cap_ready low for 1 cycle during CAPTURE -> ovf_err = 1 and stays set until the next start; word count unchanged.
- With ACQ_PHASE_CYCLE_EN, scans=5 -> phase_sel 0,1,2,3,0 and cap_neg 0,0,1,1,0.
